rf_multiport_clr: RTL
=====================

// Module: rf_multiport_clr
// PURPOSE
//  Parametrised register file for the small-calculator datapath: generic width/depth,
//  two read ports with enables, one write port, optional write-to-read bypass.
//  Adds a hardware clear sequencer that walks every entry to CLR_VAL on request, with a
//  busy flag and dropped-write indication. Sits between operand decode and the ALU.
// PARAMETERS
//  DATA_W   3     entry width in bits
//  ADDR_W   2     address width; DEPTH = 2**ADDR_W entries
//  BYPASS   1     1: same-cycle write data forwarded to matching read port; 0: no forwarding
//  CLR_VAL  0     DATA_W-bit value written by the clear sequence
// PORTS
//  clk      in   1       rising-edge clock
//  rst_n    in   1       asynchronous active-low reset
//  rea      in   1       read enable, port A
//  raa      in   ADDR_W  read address, port A
//  douta    out  DATA_W  read data, port A
//  reb      in   1       read enable, port B
//  rab      in   ADDR_W  read address, port B
//  doutb    out  DATA_W  read data, port B
//  we       in   1       write enable
//  wa       in   ADDR_W  write address
//  din      in   DATA_W  write data
//  clr_req  in   1       start clear sequence (sampled in IDLE only)
//  busy     out  1       clear sequence in progress
//  wr_drop  out  1       registered pulse: write was rejected because busy
// BEHAVIOUR
//  Reset (rst_n=0, async): all entries = 0, FSM = IDLE, pointer = 0, busy = 0, wr_drop = 0.
//   Reset mid-clear aborts the sequence immediately; no partial state survives.
//  Reads: combinational, zero latency. rex=0 -> doutx = 0. rex=1 -> doutx = entry[rax],
//   except BYPASS=1 && we && !busy && wa==rax -> doutx = din. Both ports may hit same address.
//  Write: at posedge clk, we=1 && busy=0 -> entry[wa] <= din. we=0 -> entry unchanged.
//  FSM states: IDLE, CLEAR.
//   IDLE: clr_req=1 -> CLEAR, ptr <= 0. A write in that same cycle is still performed.
//   CLEAR: each cycle entry[ptr] <= CLR_VAL, ptr <= ptr+1; at ptr==DEPTH-1 -> IDLE.
//   Sequence takes exactly DEPTH cycles; busy = (state==CLEAR), high DEPTH cycles.
//   clr_req while CLEAR is ignored (no restart, no queueing).
//  While busy: we ignored; wr_drop = 1 on the next cycle for every such cycle; no bypass.
//   Reads return current array contents (already-cleared entries show CLR_VAL).
//  Pointer is ADDR_W bits; wrap from DEPTH-1 is never used (FSM exits first).
//  Widths: no arithmetic on data; din/CLR_VAL truncated/extended to DATA_W.
// STRUCTURE
//  rf_pkg: localparams ST_IDLE=1'b0, ST_CLEAR=1'b1; default DATA_W/ADDR_W for calculator.
//  Sub-module rf_clr_seq: FSM + pointer; outputs busy, clr_we, clr_addr. Top muxes
//   clr_we/clr_addr/CLR_VAL over user write port and owns array, read muxes, wr_drop.
// TESTING
//  1 Reset: rst_n=0 async mid-cycle -> douta/doutb=0 with rea=reb=1, busy=0, wr_drop=0.
//  2 Write 3'b101 @2, 3'b011 @1; rea=1 raa=2, reb=1 rab=1 -> douta=5, doutb=3; rea=0 -> douta=0.
//  3 Bypass: we=1 wa=3 din=6, raa=3 same cycle -> douta=6 (BYPASS=1) / old value (BYPASS=0).
//  4 Fill all entries 7, pulse clr_req -> busy high exactly 4 cycles, all entries 0 after.
//  5 we=1 wa=0 din=4 during CLEAR -> wr_drop=1 next cycle, entry 0 ends at CLR_VAL.
//  6 rst_n low at clear cycle 2 -> busy=0 at once, all entries 0; clr_req mid-CLEAR no restart.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants for the calculator register file and its clear sequencer.
//   ST_IDLE / ST_CLEAR : clear-sequencer state encodings (1 bit, legacy-compatible)
//   RF_DATA_W / RF_ADDR_W : default entry and address widths for the calculator datapath
package rf_pkg;
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_CLEAR  = 1'b1;
    localparam int   RF_DATA_W = 3;
    localparam int   RF_ADDR_W = 2;
endpackage

// File: rtl/rf_clr_seq.sv
// rf_clr_seq: FSM that walks a pointer over every register-file entry on a clear request.
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (aborts any sequence in flight)
//   clr_req  in   start request, sampled only while idle
//   busy     out  high for exactly DEPTH cycles while clearing
//   clr_we   out  write strobe for the clear value
//   clr_addr out  entry being cleared this cycle
module rf_clr_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    logic              state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              last;
    assign last = ptr_q == {ADDR_W{1'b1}};
    // The pointer rests at 0 while idle, so it never needs to wrap from DEPTH-1.
    always_comb begin
        state_d = state_q == ST_IDLE ? (clr_req ? ST_CLEAR : ST_IDLE) : (last ? ST_IDLE : ST_CLEAR);
        ptr_d   = (state_q == ST_CLEAR && !last) ? ptr_q + 1'b1 : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end
    assign busy     = state_q == ST_CLEAR;
    assign clr_we   = busy;
    assign clr_addr = ptr_q;
endmodule

// File: rtl/rf_multiport_clr.sv
// rf_multiport_clr: 2-read / 1-write register file with optional write bypass and a hardware clear sequence.
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   rea, raa, douta   read port A: enable, address, combinational data (0 when disabled)
//   reb, rab, doutb   read port B: same as port A
//   we, wa, din       write port, ignored while a clear is running
//   clr_req           start clearing every entry to CLR_VAL
//   busy              clear sequence in progress
//   wr_drop           registered pulse: a write was rejected in the previous cycle
module rf_multiport_clr
    import rf_pkg::*;
#(
    parameter int                  DATA_W  = RF_DATA_W,
    parameter int                  ADDR_W  = RF_ADDR_W,
    parameter int                  BYPASS  = 1,
    parameter logic [DATA_W-1:0]   CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rea,
    input  logic [ADDR_W-1:0] raa,
    output logic [DATA_W-1:0] douta,
    input  logic              reb,
    input  logic [ADDR_W-1:0] rab,
    output logic [DATA_W-1:0] doutb,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_drop_q, wr_drop_d;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              byp;
    rf_clr_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );
    assign user_we = we && !busy;
    // Forwarding only applies to writes that will actually land.
    assign byp     = (BYPASS != 0) && user_we;
    always_comb begin
        mem_d = mem_q;
        if (clr_we) mem_d[clr_addr] = CLR_VAL;
        else if (user_we) mem_d[wa] = din;
        wr_drop_d = we && busy;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '{default: '0};
            wr_drop_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_drop_q <= wr_drop_d;
        end
    end
    assign douta   = !rea ? '0 : (byp && wa == raa) ? din : mem_q[raa];
    assign doutb   = !reb ? '0 : (byp && wa == rab) ? din : mem_q[rab];
    assign wr_drop = wr_drop_q;
endmodule
